// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, the timeout default,
// the FSM state encoding and a helper that sizes the wait counter.
package mem_stage_pkg;

  localparam int DATA_WIDTH_DEF = 16;  // datapath, address and memory word width
  localparam int REG_W_DEF      = 3;   // register index width (8 registers)
  localparam int TIMEOUT_DEF    = 15;  // cycles to wait for memAck; 0 = forever

  typedef enum logic {
    RUN    = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Width needed to count up to TIMEOUT; kept at least 1 bit so the
  // wait-forever configuration still elaborates a legal counter.
  function automatic int cnt_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_stage_wait_timer.sv
// Memory-access wait timer.
// Counts ACCESS cycles that end without memAck and flags the cycle whose
// closing edge would bring the count to TIMEOUT, so the caller can abort on
// that same edge.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   clear         hold the count at zero (asserted outside ACCESS)
//   enable        this cycle is an ACCESS cycle without memAck
//   expired       this cycle is the TIMEOUT-th ack-less cycle
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // enable is low when memAck is present, so an ack in the last cycle wins.
  assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage.
// Captures EX results into an EX/MEM register, resolves taken branches into a
// one-cycle pcSrc pulse, runs loads/stores over a memReq/memAck handshake
// (stalling upstream while an access is open, with an optional timeout) and
// presents a registered MEM/WB result as a one-cycle wbValid pulse.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   exValid, Branch, Zero, jumpResult EX instruction and branch resolution
//   outputALU, storeData              ALU result / address, store data
//   MemRead, MemWrite, RegWrite, rd   instruction controls and destination
//   stall                             EX/ID hold (combinational from state)
//   pcSrc, branchTarget               taken-branch pulse and target
//   memReq, memWe, memAddr, memWdata  memory request side
//   memRdata, memAck                  memory response side
//   wbValid, wbRegWrite, wbRd, wbData MEM/WB write-back entry
//   memErr                            sticky access-timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_W      = REG_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exValid,
  input  logic                  Branch,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] jumpResult,
  input  logic [DATA_WIDTH-1:0] outputALU,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegWrite,
  input  logic [REG_W-1:0]      rd,
  output logic                  stall,
  output logic                  pcSrc,
  output logic [DATA_WIDTH-1:0] branchTarget,
  output logic                  memReq,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck,
  output logic                  wbValid,
  output logic                  wbRegWrite,
  output logic [REG_W-1:0]      wbRd,
  output logic [DATA_WIDTH-1:0] wbData,
  output logic                  memErr
);

  // EX/MEM register contents needed to finish a memory access.
  typedef struct packed {
    logic                  mem_write;
    logic                  reg_write;
    logic [REG_W-1:0]      rd;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } exmem_t;

  state_e                state_q, state_d;
  exmem_t                exmem_q, exmem_d;
  logic                  pc_src_q, pc_src_d;
  logic [DATA_WIDTH-1:0] branch_target_q, branch_target_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]      wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  mem_err_q, mem_err_d;
  logic                  timer_expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == RUN),
    .enable  ((state_q == ACCESS) && !memAck),
    .expired (timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    exmem_d         = exmem_q;
    pc_src_d        = 1'b0;
    branch_target_d = branch_target_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    mem_err_d       = mem_err_q;

    unique case (state_q)
      RUN: begin
        // Capture every edge; exValid only gates the side effects.
        exmem_d         = '{mem_write: MemWrite, reg_write: RegWrite, rd: rd,
                            addr: outputALU, wdata: storeData};
        branch_target_d = jumpResult;
        if (exValid) begin
          pc_src_d = Branch & Zero;
          if (MemRead | MemWrite) begin
            // Read+write together behaves as a store via MemWrite.
            state_d   = ACCESS;
            mem_req_d = 1'b1;
            mem_we_d  = MemWrite;
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = RegWrite;
            wb_rd_d        = rd;
            wb_data_d      = outputALU;
          end
        end
      end
      ACCESS: begin
        if (memAck) begin
          state_d        = RUN;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = exmem_q.reg_write & ~exmem_q.mem_write;
          wb_rd_d        = exmem_q.rd;
          wb_data_d      = exmem_q.mem_write ? exmem_q.addr : memRdata;
        end else if (timer_expired) begin
          state_d        = RUN;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          mem_err_d      = 1'b1;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_rd_d        = exmem_q.rd;
          wb_data_d      = exmem_q.addr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      exmem_q         <= '0;
      pc_src_q        <= 1'b0;
      branch_target_q <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      exmem_q         <= exmem_d;
      pc_src_q        <= pc_src_d;
      branch_target_q <= branch_target_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign stall        = (state_q == ACCESS);
  assign pcSrc        = pc_src_q;
  assign branchTarget = branch_target_q;
  assign memReq       = mem_req_q;
  assign memWe        = mem_we_q;
  assign memAddr      = exmem_q.addr;
  assign memWdata     = exmem_q.wdata;
  assign wbValid      = wb_valid_q;
  assign wbRegWrite   = wb_reg_write_q;
  assign wbRd         = wb_rd_q;
  assign wbData       = wb_data_q;
  assign memErr       = mem_err_q;

endmodule
